priority_encoder_rr: RTL and testbench
======================================

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 SHALL have parameter N, default 8: number of request bits, N >= 2.
REQ-002 SHALL have parameter W, default $clog2(N): width of the encoded index.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, N: request vector to encode.
REQ-006 SHALL have port rr_en, input, 1: 1 = round-robin priority, 0 = fixed priority with MSB highest.
REQ-007 SHALL have port in_valid, input, 1: req and rr_en are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: block can accept a request this cycle.
REQ-009 SHALL have port out_valid, output, 1: out_idx and out_none hold a result.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result this cycle.
REQ-011 SHALL have port out_idx, output, W: encoded winning index.
REQ-012 SHALL have port out_none, output, 1: the accepted req was all-zero.

Function
REQ-013 SHALL define accept = in_valid && in_ready and consume = out_valid && out_ready.
REQ-014 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-015 SHALL register the result on accept, so out_valid rises the cycle after accept (latency 1).
REQ-016 SHALL hold out_valid, out_idx and out_none stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid on a consume without a simultaneous accept.
REQ-018 SHALL load the new result on the same edge when accept and consume coincide, keeping out_valid=1 (full throughput).
REQ-019 SHALL, in fixed mode (rr_en=0 at accept), set out_idx to the highest set bit index of req.
REQ-020 SHALL hold an internal pointer ptr, W bits, in range 0..N-1.
REQ-021 SHALL, in round-robin mode, search from ptr downward with wrap: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-022 SHALL set out_idx to the first set bit found by that search.
REQ-023 SHALL, on a round-robin accept with req != 0 and winner g, set ptr to (g-1) mod N; for g=0 that is N-1.
REQ-024 SHALL leave ptr unchanged on fixed-mode accepts, on zero-req accepts, and when no accept occurs.
REQ-025 SHALL, for req == 0, set out_none=1 and out_idx=0; for any nonzero req, set out_none=0.
REQ-026 SHALL sample rr_en only at accept; changing rr_en between accepts does not alter ptr.
REQ-027 SHALL ignore req and rr_en when in_valid=0 or in_ready=0.

Reset
REQ-028 SHALL, while rst=1, force out_valid=0, out_idx=0, out_none=0 and ptr=N-1, independent of clk.
REQ-029 SHALL discard any pending result when rst is asserted mid-operation.
REQ-030 SHALL accept a request on the first rising edge after rst deasserts, since in_ready=1 out of reset.

Structure
REQ-031 SHALL place the shared constants (default N) and an index-width helper function in package priority_encoder_pkg.
REQ-032 SHALL instantiate one combinational sub-module, prio_enc_fixed #(N): highest-set-bit encoder with a none flag.
REQ-033 SHALL implement round-robin as: rotate req by ptr, encode with prio_enc_fixed, un-rotate the index modulo N.
REQ-034 SHALL register state only in priority_encoder_rr: output register and ptr.

Verification (N=8)
REQ-035 SHALL verify reset: assert rst mid-stream -> out_valid=0, out_idx=0, in_ready=1, ptr=7 immediately; result discarded.
REQ-036 SHALL verify fixed mode: rr_en=0, req=8'b0010_0110 -> next cycle out_valid=1, out_idx=5, out_none=0; ptr stays 7.
REQ-037 SHALL verify round-robin rotation: rr_en=1, req=8'hFF on three back-to-back accepts, out_ready=1 -> out_idx 7, 6, 5; ptr ends at 4.
REQ-038 SHALL verify round-robin wrap: after ptr=0, req=8'b1000_0001 -> out_idx=0, ptr=7; then the same req -> out_idx=7, ptr=6.
REQ-039 SHALL verify zero request: req=8'h00 -> out_none=1, out_idx=0, ptr unchanged.
REQ-040 SHALL verify backpressure: out_ready=0 for 3 cycles -> in_ready=0, outputs held, second req not accepted; out_ready=1 with in_valid=1 -> consume and accept on the same edge, out_valid stays 1.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared constants and helpers for the priority encoder block.
// Pure declarations: no logic, no latency, no flow control.
package priority_encoder_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Width of an index into an n-bit vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_rr_if.sv
// Request/result handshake bundle between a producer, the encoder and a consumer.
// Wires only: latency and backpressure belong to the modules on either side.
interface priority_encoder_rr_if
    import priority_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = idx_width(N)
);
    logic [N-1:0] req;
    logic         rr_en;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_none;

    modport master (
        output req, rr_en, in_valid, out_ready,
        input  in_ready, out_valid, out_idx, out_none
    );

    modport slave (
        input  req, rr_en, in_valid, out_ready,
        output in_ready, out_valid, out_idx, out_none
    );
endinterface

// File: rtl/prio_enc_fixed.sv
// Highest-set-bit encoder with an all-zero flag; index is 0 when nothing is set.
// Purely combinational: zero latency, no flow control.
module prio_enc_fixed
    import priority_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         none_o
);

    // Ascending scan so the last hit, the highest set bit, wins.
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o  = W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_rr.sv
// Fixed or round-robin priority encoder with a one-deep registered result.
// Latency 1; in_ready drops while a held result is not consumed.
module priority_encoder_rr
    import priority_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic clk,
    input  logic rst,
    priority_encoder_rr_if.slave bus
);

    logic         out_valid_q;
    logic [W-1:0] out_idx_q;
    logic         out_none_q;
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    mode_e          mode;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   enc_in;
    logic [W-1:0]   enc_idx;
    logic           enc_none;
    logic [W-1:0]   win_idx;
    logic           accept;
    logic           consume;

    assign mode    = mode_e'(bus.rr_en);
    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = out_valid_q && bus.out_ready;

    // Rotate so req[ptr] lands on the MSB; the fixed encoder then searches ptr, ptr-1, ... with wrap.
    assign req_dbl = {bus.req, bus.req};
    assign rot     = N'(req_dbl >> (int'(ptr_q) + 1));
    assign enc_in  = (mode == MODE_RR) ? rot : bus.req;

    prio_enc_fixed #(.N(N), .W(W)) u_enc (
        .req_i  (enc_in),
        .idx_o  (enc_idx),
        .none_o (enc_none)
    );

    always_comb begin
        int g;
        g       = (int'(enc_idx) + int'(ptr_q) + 1) % N;
        win_idx = enc_idx;
        ptr_d   = ptr_q;
        if (mode == MODE_RR && !enc_none) begin
            win_idx = W'(g);
            ptr_d   = (g == 0) ? W'(N - 1) : W'(g - 1);
        end
        if (enc_none) begin
            win_idx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            ptr_q       <= W'(N - 1);
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_idx_q   <= win_idx;
            out_none_q  <= enc_none;
            ptr_q       <= ptr_d;
        end else if (consume) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_none  = out_none_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr (N=8): directed table, corner sequences, randomized model compare.
module tb_priority_encoder_rr;
    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    priority_encoder_rr_if #(.N(N), .W(W)) bus ();
    priority_encoder_rr #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] req;
        logic       rr;
        int         idx;
        int         none;
        int         ptr;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference winner straight from the priority rules; -1 means no bit set.
    function automatic int winner(input logic [7:0] r, input logic rr, input int p);
        if (!rr) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (p - k + N) % N;
                if (r[i]) return i;
            end
        end
        return -1;
    endfunction

    initial begin
        int m_ptr, m_idx, w;
        logic m_valid, m_none, acc;

        tbl[0]  = '{8'h26, 1'b0, 5, 0, 7};
        tbl[1]  = '{8'hFF, 1'b1, 7, 0, 6};
        tbl[2]  = '{8'hFF, 1'b1, 6, 0, 5};
        tbl[3]  = '{8'hFF, 1'b1, 5, 0, 4};
        tbl[4]  = '{8'h00, 1'b1, 0, 1, 4};
        tbl[5]  = '{8'h02, 1'b1, 1, 0, 0};
        tbl[6]  = '{8'h81, 1'b1, 0, 0, 7};
        tbl[7]  = '{8'h81, 1'b1, 7, 0, 6};
        tbl[8]  = '{8'h10, 1'b0, 4, 0, 6};
        tbl[9]  = '{8'h00, 1'b0, 0, 1, 6};
        tbl[10] = '{8'h21, 1'b1, 5, 0, 4};

        rst = 1'b1;
        bus.req = '0; bus.rr_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_idx",   int'(bus.out_idx), 0);
        chk("rst_out_none",  int'(bus.out_none), 0);
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        chk("rst_ptr",       int'(dut.ptr_q), 7);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            bus.req = tbl[i].req; bus.rr_en = tbl[i].rr; bus.in_valid = 1'b1;
            cyc();
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d_valid", i), int'(bus.out_valid), 1);
            chk($sformatf("tbl%0d_idx", i),   int'(bus.out_idx), tbl[i].idx);
            chk($sformatf("tbl%0d_none", i),  int'(bus.out_none), tbl[i].none);
            chk($sformatf("tbl%0d_ptr", i),   int'(dut.ptr_q), tbl[i].ptr);
            cyc();
            chk($sformatf("tbl%0d_drain", i), int'(bus.out_valid), 0);
        end

        // rr_en and req wiggling without in_valid must not move ptr.
        for (int i = 0; i < 3; i++) begin
            bus.rr_en = ~bus.rr_en; bus.req = 8'hA5 ^ 8'(i);
            cyc();
            chk("idle_ptr", int'(dut.ptr_q), 4);
            chk("idle_valid", int'(bus.out_valid), 0);
        end

        // Backpressure: first result held, second request stalled until out_ready.
        bus.out_ready = 1'b0;
        bus.req = 8'h04; bus.rr_en = 1'b0; bus.in_valid = 1'b1;
        cyc();
        chk("bp_first_idx", int'(bus.out_idx), 2);
        bus.req = 8'h40;
        #1;
        chk("bp_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_ready", int'(bus.in_ready), 0);
            chk("bp_hold_valid", int'(bus.out_valid), 1);
            chk("bp_hold_idx",   int'(bus.out_idx), 2);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(bus.in_ready), 1);
        cyc();
        bus.in_valid = 1'b0;
        chk("bp_swap_valid", int'(bus.out_valid), 1);
        chk("bp_swap_idx",   int'(bus.out_idx), 6);
        cyc();
        chk("bp_drain", int'(bus.out_valid), 0);

        // Mid-stream reset drops a pending result and restores ptr without a clock edge.
        bus.out_ready = 1'b0;
        bus.req = 8'hFF; bus.rr_en = 1'b1; bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("mid_idx", int'(bus.out_idx), 4);
        chk("mid_ptr", int'(dut.ptr_q), 3);
        #2 rst = 1'b1;
        #1;
        chk("mrst_valid",    int'(bus.out_valid), 0);
        chk("mrst_idx",      int'(bus.out_idx), 0);
        chk("mrst_in_ready", int'(bus.in_ready), 1);
        chk("mrst_ptr",      int'(dut.ptr_q), 7);
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;

        m_valid = 1'b0; m_idx = 0; m_none = 1'b0; m_ptr = 7;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.rr_en     = 1'($urandom_range(0, 1));
            bus.req       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom & $urandom);
            #1;
            chk("rnd_in_ready", int'(bus.in_ready), int'(!m_valid || bus.out_ready));
            acc = bus.in_valid && (!m_valid || bus.out_ready);
            if (acc) begin
                w = winner(bus.req, bus.rr_en, m_ptr);
                m_valid = 1'b1;
                m_none  = (w < 0);
                m_idx   = (w < 0) ? 0 : w;
                if (bus.rr_en && w >= 0) m_ptr = (w + N - 1) % N;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 1'b0;
            end
            cyc();
            chk("rnd_valid", int'(bus.out_valid), int'(m_valid));
            if (m_valid) begin
                chk("rnd_idx",  int'(bus.out_idx), m_idx);
                chk("rnd_none", int'(bus.out_none), int'(m_none));
            end
            chk("rnd_ptr", int'(dut.ptr_q), m_ptr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
